// File: rtl/imem_arb_pkg.sv
// Shared constants and types for the instruction-ROM port arbiter.
package imem_arb_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [31:0] ROM_BASE   = 32'hBFC0_0000;
    localparam int unsigned ROM_BYTES  = 4096;

    // Which requester owns the ROM this cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_LD
    } gnt_e;

    // One registered response toward a requester.
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Request/response bundle between one ROM requester and the arbiter.
interface imem_port_arbiter_if #(
    parameter int unsigned DW = imem_arb_pkg::DATA_WIDTH
);
    logic          req_valid;
    logic [DW-1:0] req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    // Requester side: issues the address, consumes the response pulse.
    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    // Arbiter side.
    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );
endinterface

// File: rtl/imem_range_check.sv
// Translates a CPU byte address into a ROM byte offset and flags
// addresses that are misaligned or fall outside the ROM window.
module imem_range_check #(
    parameter int unsigned AW    = imem_arb_pkg::DATA_WIDTH,
    parameter logic [31:0] BASE  = imem_arb_pkg::ROM_BASE,
    parameter int unsigned BYTES = imem_arb_pkg::ROM_BYTES
) (
    input  logic [AW-1:0] addr,
    output logic [AW-1:0] off,
    output logic          ok
);
    import imem_arb_pkg::*;

    localparam logic [AW-1:0] BASE_AW  = AW'(BASE);
    localparam logic [AW-1:0] LAST_OFF = AW'(BYTES - 4);

    // Wrapping subtract: addresses below the base land high and fail the compare.
    always_comb begin
        off = addr - BASE_AW;
        ok  = (addr[1:0] == 2'b00) && (off <= LAST_OFF);
    end
endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the asynchronous-read instruction ROM between fetch (IF) and the
// load path (LD). LD wins by default; a saturating counter of denied fetch
// cycles hands the port to IF once it reaches STARVE_LIMIT. Responses are
// registered and pulse for one cycle on the granted side.
module imem_port_arbiter #(
    parameter int unsigned DATA_WIDTH   = imem_arb_pkg::DATA_WIDTH,
    parameter logic [31:0] ROM_BASE     = imem_arb_pkg::ROM_BASE,
    parameter int unsigned ROM_BYTES    = imem_arb_pkg::ROM_BYTES,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_port_arbiter_if.slave    if_port,
    imem_port_arbiter_if.slave    ld_port,
    output logic [DATA_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout
);
    import imem_arb_pkg::*;

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    gnt_e                  gnt;
    logic [DATA_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_off;
    logic                  gnt_ok;
    logic [DATA_WIDTH-1:0] gnt_data;

    logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;
    rsp_t             if_rsp_d, if_rsp_q;
    rsp_t             ld_rsp_d, ld_rsp_q;

    // Grant selection: starved fetch first, then load, then fetch alone.
    always_comb begin
        gnt = GNT_NONE;
        if (rst_n) begin
            if (if_port.req_valid && (starve_cnt_q == CNT_MAX)) begin
                gnt = GNT_IF;
            end else if (ld_port.req_valid) begin
                gnt = GNT_LD;
            end else if (if_port.req_valid) begin
                gnt = GNT_IF;
            end
        end
    end

    // Route the winning address through the single range checker.
    always_comb begin
        gnt_addr = '0;
        case (gnt)
            GNT_IF:  gnt_addr = if_port.req_addr;
            GNT_LD:  gnt_addr = ld_port.req_addr;
            default: gnt_addr = '0;
        endcase
    end

    imem_range_check #(
        .AW    (DATA_WIDTH),
        .BASE  (ROM_BASE),
        .BYTES (ROM_BYTES)
    ) u_range_check (
        .addr (gnt_addr),
        .off  (gnt_off),
        .ok   (gnt_ok)
    );

    // ROM address, readys and the word a bad address returns (zero).
    always_comb begin
        if_port.req_ready = (gnt == GNT_IF);
        ld_port.req_ready = (gnt == GNT_LD);
        rom_addr          = ((gnt != GNT_NONE) && gnt_ok) ? gnt_off : '0;
        gnt_data          = gnt_ok ? rom_dout : '0;
    end

    // Starvation count: grows while fetch waits, clears on grant or idle.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_port.req_valid || if_port.req_ready) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Next response: one pulse on the granted side only.
    always_comb begin
        if_rsp_d = '0;
        ld_rsp_d = '0;
        if (gnt == GNT_IF) begin
            if_rsp_d.valid = 1'b1;
            if_rsp_d.data  = gnt_data;
            if_rsp_d.err   = !gnt_ok;
        end
        if (gnt == GNT_LD) begin
            ld_rsp_d.valid = 1'b1;
            ld_rsp_d.data  = gnt_data;
            ld_rsp_d.err   = !gnt_ok;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            if_rsp_q     <= '0;
            ld_rsp_q     <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            if_rsp_q     <= if_rsp_d;
            ld_rsp_q     <= ld_rsp_d;
        end
    end

    // Responses are masked while reset is low so a request accepted just
    // before reset never shows a pulse.
    always_comb begin
        if_port.rsp_valid = if_rsp_q.valid & rst_n;
        if_port.rsp_data  = rst_n ? if_rsp_q.data : '0;
        if_port.rsp_err   = if_rsp_q.err & rst_n;
        ld_port.rsp_valid = ld_rsp_q.valid & rst_n;
        ld_port.rsp_data  = rst_n ? ld_rsp_q.data : '0;
        ld_port.rsp_err   = ld_rsp_q.err & rst_n;
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural ROM whose word at
// byte offset k holds k, except offset 0x10 which holds 0xDEADBEEF.
module tb_imem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic [31:0] rom_dout;
    logic [31:0] rom_mem [0:1023];

    int n_checks;
    int n_fail;

    imem_port_arbiter_if #(.DW(32)) if_bus ();
    imem_port_arbiter_if #(.DW(32)) ld_bus ();

    imem_port_arbiter #(
        .DATA_WIDTH   (32),
        .ROM_BASE     (32'hBFC0_0000),
        .ROM_BYTES    (4096),
        .STARVE_LIMIT (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_port  (if_bus),
        .ld_port  (ld_bus),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout)
    );

    assign rom_dout = rom_mem[rom_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // LD range-check vectors: address, expected rom_addr, err, data.
    logic [31:0] rc_addr [4] = '{32'hBFC0_1000, 32'hBFC0_0FFE, 32'hBFBF_FFFC, 32'hBFC0_0FFC};
    logic [31:0] rc_off  [4] = '{32'h0, 32'h0, 32'h0, 32'hFFC};
    logic        rc_err  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] rc_data [4] = '{32'h0, 32'h0, 32'h0, 32'hFFC};

    // Fetch-valid pattern with LD always valid; IF drops once, resetting the count.
    logic        sc_ifv [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        sc_ifr [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 32'(i * 4);
        rom_mem[4] = 32'hDEAD_BEEF;

        // Reset held with both requesters valid.
        rst_n            = 1'b0;
        if_bus.req_valid = 1'b1;
        if_bus.req_addr  = 32'hBFC0_0200;
        ld_bus.req_valid = 1'b1;
        ld_bus.req_addr  = 32'hBFC0_0100;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_if_ready", 32'(if_bus.req_ready), 32'd0);
            check("rst_ld_ready", 32'(ld_bus.req_ready), 32'd0);
            check("rst_if_rsp_valid", 32'(if_bus.rsp_valid), 32'd0);
            check("rst_ld_rsp_valid", 32'(ld_bus.rsp_valid), 32'd0);
            check("rst_if_rsp_data", if_bus.rsp_data, 32'd0);
            check("rst_ld_rsp_err", 32'(ld_bus.rsp_err), 32'd0);
            check("rst_rom_addr", rom_addr, 32'd0);
        end
        tick();
        rst_n = 1'b1;

        // Continuous contention: LD x4, then IF once, repeating.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("cont_ld_ready", 32'(ld_bus.req_ready), 32'((c % 5) != 4));
            check("cont_if_ready", 32'(if_bus.req_ready), 32'((c % 5) == 4));
            check("cont_rom_addr", rom_addr, ((c % 5) == 4) ? 32'h200 : 32'h100);
            if (c > 0) begin
                check("cont_ld_rsp_valid", 32'(ld_bus.rsp_valid), 32'(((c - 1) % 5) != 4));
                check("cont_if_rsp_valid", 32'(if_bus.rsp_valid), 32'(((c - 1) % 5) == 4));
                if (((c - 1) % 5) == 4) check("cont_if_rsp_data", if_bus.rsp_data, 32'h200);
                else                    check("cont_ld_rsp_data", ld_bus.rsp_data, 32'h100);
            end
            tick();
        end
        if_bus.req_valid = 1'b0;
        ld_bus.req_valid = 1'b0;
        @(negedge clk);
        check("idle_if_ready", 32'(if_bus.req_ready), 32'd0);
        check("idle_ld_ready", 32'(ld_bus.req_ready), 32'd0);
        check("idle_rom_addr", rom_addr, 32'd0);
        check("last_if_rsp_valid", 32'(if_bus.rsp_valid), 32'd1);
        check("last_if_rsp_data", if_bus.rsp_data, 32'h200);

        // Starvation count clears when fetch drops its request.
        ld_bus.req_addr = 32'hBFC0_0100;
        if_bus.req_addr = 32'hBFC0_0200;
        for (int c = 0; c < 9; c++) begin
            tick();
            ld_bus.req_valid = 1'b1;
            if_bus.req_valid = sc_ifv[c];
            @(negedge clk);
            check($sformatf("starve_if_ready_%0d", c), 32'(if_bus.req_ready), 32'(sc_ifr[c]));
            check($sformatf("starve_ld_ready_%0d", c), 32'(ld_bus.req_ready), 32'(!sc_ifr[c]));
        end
        tick();
        if_bus.req_valid = 1'b0;
        ld_bus.req_valid = 1'b0;
        tick();

        // Single fetch from the preloaded word.
        if_bus.req_valid = 1'b1;
        if_bus.req_addr  = 32'hBFC0_0010;
        @(negedge clk);
        check("fetch_rom_addr", rom_addr, 32'h10);
        check("fetch_if_ready", 32'(if_bus.req_ready), 32'd1);
        tick();
        if_bus.req_valid = 1'b0;
        @(negedge clk);
        check("fetch_rsp_valid", 32'(if_bus.rsp_valid), 32'd1);
        check("fetch_rsp_data", if_bus.rsp_data, 32'hDEAD_BEEF);
        check("fetch_rsp_err", 32'(if_bus.rsp_err), 32'd0);
        check("fetch_ld_rsp_valid", 32'(ld_bus.rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        check("fetch_pulse_end", 32'(if_bus.rsp_valid), 32'd0);

        // LD range and alignment boundaries, issued back to back.
        for (int i = 0; i <= 4; i++) begin
            tick();
            ld_bus.req_valid = (i < 4);
            if (i < 4) ld_bus.req_addr = rc_addr[i];
            @(negedge clk);
            if (i < 4) begin
                check($sformatf("range_ready_%0d", i), 32'(ld_bus.req_ready), 32'd1);
                check($sformatf("range_rom_addr_%0d", i), rom_addr, rc_off[i]);
            end
            if (i > 0) begin
                check($sformatf("range_rsp_valid_%0d", i - 1), 32'(ld_bus.rsp_valid), 32'd1);
                check($sformatf("range_rsp_err_%0d", i - 1), 32'(ld_bus.rsp_err), 32'(rc_err[i - 1]));
                check($sformatf("range_rsp_data_%0d", i - 1), ld_bus.rsp_data, rc_data[i - 1]);
            end
        end

        // Back-to-back fetches of words 0, 4, 8.
        for (int i = 0; i <= 3; i++) begin
            tick();
            if_bus.req_valid = (i < 3);
            if (i < 3) if_bus.req_addr = 32'hBFC0_0000 + 32'(i * 4);
            @(negedge clk);
            if (i < 3) check($sformatf("b2b_ready_%0d", i), 32'(if_bus.req_ready), 32'd1);
            if (i > 0) begin
                check($sformatf("b2b_rsp_valid_%0d", i - 1), 32'(if_bus.rsp_valid), 32'd1);
                check($sformatf("b2b_rsp_data_%0d", i - 1), if_bus.rsp_data, 32'((i - 1) * 4));
            end
        end
        @(negedge clk);
        check("b2b_pulse_end", 32'(if_bus.rsp_valid), 32'd0);

        // Reset right after an LD acceptance: no response may appear.
        tick();
        ld_bus.req_valid = 1'b1;
        ld_bus.req_addr  = 32'hBFC0_0020;
        @(negedge clk);
        check("mid_rst_ld_ready", 32'(ld_bus.req_ready), 32'd1);
        tick();
        rst_n            = 1'b0;
        ld_bus.req_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", 32'(ld_bus.rsp_valid), 32'd0);
        check("mid_rst_rsp_data", ld_bus.rsp_data, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", 32'(ld_bus.rsp_valid), 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single asynchronous-read instruction ROM (4 KiB, mapped 0xBFC00000–0xBFC00FFF, byte-addressed, little-endian word output) between two requesters.
- Requester 1 is the fetch stage (IF); requester 2 is the load path (LD), which reads constants and rodata from ROM space.
- Grants at most one word read per cycle, translates the CPU address to a ROM byte offset, and range/alignment-checks it.
- Returns a registered response with a starvation guard for fetch.

Parameters:
- DATA_WIDTH, 32, address/data width.
- ROM_BASE, 32'hBFC00000, CPU address of ROM byte 0.
- ROM_BYTES, 4096, ROM size in bytes.
- STARVE_LIMIT, 4, number of consecutive denied fetch cycles after which fetch wins.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- if_req_valid  in  1  fetch request
- if_req_addr  in  32  fetch CPU byte address
- if_req_ready  out  1  fetch request granted this cycle
- if_rsp_valid  out  1  fetch response pulse
- if_rsp_data  out  32  fetched word
- if_rsp_err  out  1  fetch address out of range or misaligned
- ld_req_valid  in  1  load request
- ld_req_addr  in  32  load CPU byte address
- ld_req_ready  out  1  load request granted this cycle
- ld_rsp_valid  out  1  load response pulse
- ld_rsp_data  out  32  loaded word
- ld_rsp_err  out  1  load address out of range or misaligned
- rom_addr  out  32  ROM byte offset, drives ROM addr
- rom_dout  in  32  ROM read word, combinational from rom_addr

Behaviour:
- Handshake
  - A request is accepted when valid && ready in the same cycle.
  - The requester holds valid and addr stable until ready.
  - ready is combinational from the valids and the starvation state; ready is never asserted without valid.
- Arbitration
  - Default: LD has priority.
  - If starve_cnt == STARVE_LIMIT and if_req_valid, IF is granted instead.
  - Exactly one grant per cycle; no grant if neither requester is valid.
- Starvation counter starve_cnt, width clog2(STARVE_LIMIT+1):
  - Increments when if_req_valid && !if_req_ready; saturates at STARVE_LIMIT.
  - Clears to 0 when IF is granted or if_req_valid == 0.
- Address translation and check for the granted request
  - off = addr - ROM_BASE, computed in 32-bit arithmetic with wrap.
  - ok = (addr[1:0] == 0) && (off <= ROM_BYTES-4). Unsigned compare, so addresses below ROM_BASE wrap high and fail.
  - rom_addr = off when ok, else 0. With no grant, rom_addr = 0.
- Latency
  - Response arrives 1 cycle after acceptance.
  - On the next rising edge the arbiter registers rsp_data = ok ? rom_dout : 0 and rsp_err = !ok, and pulses rsp_valid for exactly one cycle on the granted side only.
  - Back-to-back acceptances give back-to-back pulses.
  - There is no response backpressure: requesters must consume the response in its pulse cycle.
- Reset
  - While rst_n == 0 at a rising edge: all rsp_valid = 0, rsp_data = 0, rsp_err = 0, starve_cnt = 0.
  - A request accepted in the cycle before reset produces no response.
  - ready outputs are forced to 0 while rst_n == 0.
- Simultaneous events
  - IF and LD both valid with starve_cnt < LIMIT: LD is granted, IF waits.
  - At LIMIT: IF is granted, LD waits one cycle.
- Boundaries
  - addr 0xBFC00FFC is ok.
  - 0xBFC01000 is an error, as is 0xBFBFFFFC.
  - Any addr[1:0] != 0 is an error.
  - An error still consumes the grant and yields one response with data 0.

Decomposition:
- Package imem_arb_pkg holds:
  - ROM_BASE and ROM_BYTES constants.
  - typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_LD} gnt_e.
  - The response struct {valid, data, err}.
- One combinational sub-module, imem_range_check: addr in, off and ok out. It is instantiated once on the granted address.
- The top holds the grant logic, starve_cnt and the two response registers.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with both valids high -> readys = 0, all rsp outputs = 0; first cycle after release, LD is granted.
- Single fetch: ROM preload word at offset 0x10 = 0xDEADBEEF; if_req_addr 0xBFC00010 -> rom_addr = 0x10, if_req_ready = 1; next cycle if_rsp_valid = 1, data = 0xDEADBEEF, err = 0.
- Contention/starvation: both valid continuously with LIMIT = 4 -> LD granted cycles 0–3, IF granted cycle 4, starve_cnt returns to 0; pattern repeats every 5 cycles.
- Range errors: ld_req_addr 0xBFC01000, then 0xBFC00FFE, then 0xBFBFFFFC -> each yields ld_rsp_err = 1 and data = 0. 0xBFC00FFC returns rom word 0xFFC with err = 0.
- Back-to-back: IF valid alone for 3 cycles with addrs 0xBFC00000/04/08 -> three consecutive if_rsp_valid pulses carrying words 0, 4, 8.
- Reset mid-operation: LD accepted at cycle n, rst_n = 0 at n+1 -> no ld_rsp_valid ever appears for that request.
